// File: rtl/serial_cascade_compare_if.sv
// Request/result bundle for the serial cascade comparator.
// The master drives the operands and start; the slave returns busy/done and the one-hot result.
interface serial_cascade_compare_if #(
  parameter int WIDTH = 16
);
  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
  logic             oBusy;
  logic             oDone;
  logic             oErr;
  logic [2:0]       oData;

  modport master (
    output iStart, iData_a, iData_b, iData,
    input  oBusy, oDone, oErr, oData
  );

  modport slave (
    input  iStart, iData_a, iData_b, iData,
    output oBusy, oDone, oErr, oData
  );
endinterface

// File: rtl/serial_cascade_compare.sv
// Wide unsigned magnitude compare, one 4-bit cascade slice per clock, LSB slice first.
// Latency NIBBLES cycles from accepted start to oDone; iStart is ignored while busy (no queuing).
module serial_cascade_compare #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  serial_cascade_compare_if.slave    bus
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       run_q;
  logic [2:0]       run_d;
  logic             err_q;
  logic             busy_q;
  logic             done_q;
  logic             oerr_q;
  logic [2:0]       data_q;
  logic             cin_ok;

  // Operands shift right each slice, so the active slice always sits in the low nibble.
  always_comb begin
    run_d = run_q;
    if (a_q[3:0] > b_q[3:0]) begin
      run_d = 3'b100;
    end else if (a_q[3:0] < b_q[3:0]) begin
      run_d = 3'b010;
    end
  end

  always_comb begin
    cin_ok = 1'b0;
    case (bus.iData)
      3'b100, 3'b010, 3'b001: cin_ok = 1'b1;
      default:                cin_ok = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      run_q   <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oerr_q  <= 1'b0;
      data_q  <= 3'b000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iStart) begin
            a_q     <= bus.iData_a;
            b_q     <= bus.iData_b;
            run_q   <= cin_ok ? bus.iData : 3'b001;
            err_q   <= ~cin_ok;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          run_q <= run_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            data_q  <= run_d;
            oerr_q  <= err_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oErr  = oerr_q;
  assign bus.oData = data_q;

endmodule
